tm_lif_array: RTL and testbench

Parametrised, time-multiplexed array of leaky integrate-and-fire neurons. One shared update datapath visits neurons in round-robin order, one per accepted input beat. Adds the following:
- Configurable width, neuron count and leak.
- Per-neuron programmable thresholds.
- Refractory period.
- Selectable post-spike reset mode.
- Saturating arithmetic.
- Back-pressured spike event output.

Sits between the stimulus/current source and the spike-routing logic.

---
 rtl/tm_lif_array_if.sv | 27 ++
 rtl/tm_lif_array.sv | 102 ++++++++++
 tb/tb_tm_lif_array.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tm_lif_array_if.sv
// tm_lif_array_if: current-in / spike-event-out / threshold-config bundle of the LIF array
interface tm_lif_array_if #(
    parameter int WIDTH     = 8,
    parameter int N_NEURONS = 8,
    parameter int IDX_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_current;
    logic [IDX_W-1:0]     cur_idx;
    logic                 cfg_we;
    logic [IDX_W-1:0]     cfg_idx;
    logic [WIDTH-1:0]     cfg_thresh;
    logic                 evt_valid;
    logic                 evt_ready;
    logic [IDX_W-1:0]     evt_idx;
    logic [N_NEURONS-1:0] spike_vec;
    logic                 frame_done;
    modport master (
        output in_valid, in_current, cfg_we, cfg_idx, cfg_thresh, evt_ready,
        input  in_ready, cur_idx, evt_valid, evt_idx, spike_vec, frame_done
    );
    modport slave (
        input  in_valid, in_current, cfg_we, cfg_idx, cfg_thresh, evt_ready,
        output in_ready, cur_idx, evt_valid, evt_idx, spike_vec, frame_done
    );
endinterface

// File: rtl/tm_lif_array.sv
// tm_lif_array: time-multiplexed leaky integrate-and-fire neuron array
// one shared update datapath visits neurons round-robin, one per accepted beat
module tm_lif_array #(
    parameter int N_NEURONS   = 8,
    parameter int WIDTH       = 8,
    parameter int LEAK_SHIFT  = 1,
    parameter int REFRACT     = 2,
    parameter int RESET_MODE  = 0,
    parameter int THRESH_INIT = 127
) (
    input logic           clk,
    input logic           rst,
    tm_lif_array_if.slave bus
);
    localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int RW    = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_NEURONS - 1);
    localparam logic [IDX_W:0]   NUM  = (IDX_W + 1)'(N_NEURONS);

    logic [WIDTH-1:0]     state_q [N_NEURONS];
    logic [WIDTH-1:0]     state_d [N_NEURONS];
    logic [WIDTH-1:0]     thresh_q [N_NEURONS];
    logic [WIDTH-1:0]     thresh_d [N_NEURONS];
    logic [RW-1:0]        refr_q [N_NEURONS];
    logic [RW-1:0]        refr_d [N_NEURONS];
    logic [IDX_W-1:0]     idx_q, idx_d, evt_idx_q, evt_idx_d;
    logic                 evt_valid_q, evt_valid_d, frame_q, frame_d;
    logic [N_NEURONS-1:0] spike_q, spike_d;
    logic [WIDTH-1:0]     leaked, sum, thr;
    logic [WIDTH:0]       sum_w;
    logic                 in_ready, accept;

    // a stalled event blocks input so a new spike can never overwrite it
    assign in_ready = !(evt_valid_q && !bus.evt_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        thresh_d    = thresh_q;
        refr_d      = refr_q;
        idx_d       = idx_q;
        evt_valid_d = evt_valid_q && !bus.evt_ready;
        evt_idx_d   = evt_idx_q;
        spike_d     = spike_q;
        frame_d     = 1'b0;
        thr         = thresh_q[idx_q];
        leaked      = state_q[idx_q] >> LEAK_SHIFT;
        sum_w       = {1'b0, leaked} + {1'b0, bus.in_current};
        sum         = sum_w[WIDTH] ? '1 : sum_w[WIDTH-1:0];
        // the update compares against thresh_q, so a same-cycle write lands next update
        if (bus.cfg_we && ({1'b0, bus.cfg_idx} < NUM))
            thresh_d[bus.cfg_idx] = bus.cfg_thresh;
        if (accept) begin
            if (refr_q[idx_q] != '0) begin
                refr_d[idx_q]  = refr_q[idx_q] - RW'(1);
                spike_d[idx_q] = 1'b0;
            end else if (sum >= thr) begin
                spike_d[idx_q] = 1'b1;
                evt_valid_d    = 1'b1;
                evt_idx_d      = idx_q;
                refr_d[idx_q]  = RW'(REFRACT);
                state_d[idx_q] = (RESET_MODE != 0) ? sum - thr : '0;
            end else begin
                spike_d[idx_q] = 1'b0;
                state_d[idx_q] = sum;
            end
            idx_d   = (idx_q == LAST) ? '0 : idx_q + IDX_W'(1);
            frame_d = (idx_q == LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                state_q[i]  <= '0;
                thresh_q[i] <= WIDTH'(THRESH_INIT);
                refr_q[i]   <= '0;
            end
            idx_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_idx_q   <= '0;
            spike_q     <= '0;
            frame_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            thresh_q    <= thresh_d;
            refr_q      <= refr_d;
            idx_q       <= idx_d;
            evt_valid_q <= evt_valid_d;
            evt_idx_q   <= evt_idx_d;
            spike_q     <= spike_d;
            frame_q     <= frame_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.cur_idx    = idx_q;
    assign bus.evt_valid  = evt_valid_q;
    assign bus.evt_idx    = evt_idx_q;
    assign bus.spike_vec  = spike_q;
    assign bus.frame_done = frame_q;
endmodule

// File: tb/tb_tm_lif_array.sv
// tb_tm_lif_array: scoreboard bench for three tm_lif_array configurations
// (defaults, subtract-threshold reset, five neurons)
module tb_tm_lif_array;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [2:0] q0[$], q1[$], q5[$];
    logic [2:0] e0, e1, e5;

    always #5 clk = ~clk;

    tm_lif_array_if #(.WIDTH(8), .N_NEURONS(8)) b0();
    tm_lif_array_if #(.WIDTH(8), .N_NEURONS(8)) b1();
    tm_lif_array_if #(.WIDTH(8), .N_NEURONS(5)) b5();

    tm_lif_array #(.N_NEURONS(8))                   u0 (.clk(clk), .rst(rst), .bus(b0));
    tm_lif_array #(.N_NEURONS(8), .RESET_MODE(1))   u1 (.clk(clk), .rst(rst), .bus(b1));
    tm_lif_array #(.N_NEURONS(5))                   u5 (.clk(clk), .rst(rst), .bus(b5));

    // each consumed event is matched against the oldest predicted spike
    always @(negedge clk) if (!rst && b0.evt_valid && b0.evt_ready) begin
        checks++;
        if (q0.size() == 0) begin
            errors++;
            $display("FAIL evt0 unexpected event got idx=%0d exp=none", b0.evt_idx);
        end else begin
            e0 = q0.pop_front();
            if (b0.evt_idx !== e0) begin
                errors++;
                $display("FAIL evt0 idx got=%0d exp=%0d", b0.evt_idx, e0);
            end
        end
    end

    always @(negedge clk) if (!rst && b1.evt_valid && b1.evt_ready) begin
        checks++;
        if (q1.size() == 0) begin
            errors++;
            $display("FAIL evt1 unexpected event got idx=%0d exp=none", b1.evt_idx);
        end else begin
            e1 = q1.pop_front();
            if (b1.evt_idx !== e1) begin
                errors++;
                $display("FAIL evt1 idx got=%0d exp=%0d", b1.evt_idx, e1);
            end
        end
    end

    always @(negedge clk) if (!rst && b5.evt_valid && b5.evt_ready) begin
        checks++;
        if (q5.size() == 0) begin
            errors++;
            $display("FAIL evt5 unexpected event got idx=%0d exp=none", b5.evt_idx);
        end else begin
            e5 = q5.pop_front();
            if (b5.evt_idx !== e5) begin
                errors++;
                $display("FAIL evt5 idx got=%0d exp=%0d", b5.evt_idx, e5);
            end
        end
    end

    task automatic idle_all();
        b0.in_valid = 0; b0.in_current = 0; b0.cfg_we = 0; b0.cfg_idx = 0; b0.cfg_thresh = 0; b0.evt_ready = 1;
        b1.in_valid = 0; b1.in_current = 0; b1.cfg_we = 0; b1.cfg_idx = 0; b1.cfg_thresh = 0; b1.evt_ready = 1;
        b5.in_valid = 0; b5.in_current = 0; b5.cfg_we = 0; b5.cfg_idx = 0; b5.cfg_thresh = 0; b5.evt_ready = 1;
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic beat(input int d, input logic [7:0] c);
        if (d == 0) begin b0.in_valid = 1; b0.in_current = c; end
        if (d == 1) begin b1.in_valid = 1; b1.in_current = c; end
        if (d == 5) begin b5.in_valid = 1; b5.in_current = c; end
        @(posedge clk); #1;
        b0.in_valid = 0; b1.in_valid = 0; b5.in_valid = 0;
    endtask

    task automatic cfg(input int d, input logic [2:0] idx, input logic [7:0] th);
        if (d == 0) begin b0.cfg_we = 1; b0.cfg_idx = idx; b0.cfg_thresh = th; end
        if (d == 5) begin b5.cfg_we = 1; b5.cfg_idx = idx; b5.cfg_thresh = th; end
        @(posedge clk); #1;
        b0.cfg_we = 0; b5.cfg_we = 0;
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1;
        @(posedge clk); #1;
        checks++; if (b0.cur_idx !== 3'd0 || b1.cur_idx !== 3'd0 || b5.cur_idx !== 3'd0) begin
            errors++; $display("FAIL reset_cur_idx got=%0d/%0d/%0d exp=0", b0.cur_idx, b1.cur_idx, b5.cur_idx); end
        checks++; if (b0.evt_valid !== 1'b0 || b1.evt_valid !== 1'b0 || b5.evt_valid !== 1'b0) begin
            errors++; $display("FAIL reset_evt_valid got=%b/%b/%b exp=0", b0.evt_valid, b1.evt_valid, b5.evt_valid); end
        checks++; if (b0.spike_vec !== 8'h00 || b5.spike_vec !== 5'h00) begin
            errors++; $display("FAIL reset_spike_vec got=%h/%h exp=0", b0.spike_vec, b5.spike_vec); end
        checks++; if (b0.frame_done !== 1'b0 || b0.evt_idx !== 3'd0 || b0.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_misc got fd=%b ei=%0d rdy=%b exp fd=0 ei=0 rdy=1", b0.frame_done, b0.evt_idx, b0.in_ready); end
        rst = 0;
    endtask

    task automatic test_frames();
        logic sp;
        do_reset();
        for (int f = 1; f <= 6; f++) begin
            for (int n = 0; n < 8; n++) begin
                sp = (f == 2 || f == 6);
                if (sp) q0.push_back(3'(n));
                beat(0, 8'd100);
                checks++; if (b0.spike_vec[n] !== sp) begin
                    errors++; $display("FAIL frames_spike f=%0d n=%0d got=%b exp=%b", f, n, b0.spike_vec[n], sp); end
                checks++; if (b0.cur_idx !== 3'((n + 1) % 8)) begin
                    errors++; $display("FAIL frames_cur_idx f=%0d got=%0d exp=%0d", f, b0.cur_idx, (n + 1) % 8); end
                checks++; if (b0.frame_done !== (n == 7)) begin
                    errors++; $display("FAIL frames_frame_done f=%0d n=%0d got=%b exp=%b", f, n, b0.frame_done, n == 7); end
            end
        end
        @(posedge clk); #1;
        checks++; if (b0.frame_done !== 1'b0) begin
            errors++; $display("FAIL frames_idle_frame_done got=%b exp=0", b0.frame_done); end
        checks++; if (q0.size() != 0) begin
            errors++; $display("FAIL frames_missing_events got=%0d pending exp=0", q0.size()); end
    endtask

    task automatic test_saturation();
        do_reset();
        cfg(0, 3'd0, 8'd255);
        beat(0, 8'd200);
        checks++; if (b0.spike_vec[0] !== 1'b0) begin
            errors++; $display("FAIL sat_prefill_spike got=%b exp=0", b0.spike_vec[0]); end
        for (int n = 1; n < 8; n++) beat(0, 8'd0);
        q0.push_back(3'd0);
        beat(0, 8'd255);
        checks++; if (b0.spike_vec[0] !== 1'b1) begin
            errors++; $display("FAIL sat_spike got=%b exp=1", b0.spike_vec[0]); end
        @(posedge clk); #1;
        checks++; if (q0.size() != 0) begin
            errors++; $display("FAIL sat_missing_events got=%0d pending exp=0", q0.size()); end
    endtask

    task automatic test_cfg_same_cycle();
        do_reset();
        b0.cfg_we = 1; b0.cfg_idx = 3'd0; b0.cfg_thresh = 8'd200;
        q0.push_back(3'd0);
        beat(0, 8'd130);
        b0.cfg_we = 0;
        checks++; if (b0.spike_vec[0] !== 1'b1) begin
            errors++; $display("FAIL cfg_old_thresh_spike got=%b exp=1", b0.spike_vec[0]); end
        b0.cfg_we = 1; b0.cfg_idx = 3'd2; b0.cfg_thresh = 8'd200;
        beat(0, 8'd0);
        b0.cfg_we = 0;
        beat(0, 8'd150);
        checks++; if (b0.spike_vec[2] !== 1'b0) begin
            errors++; $display("FAIL cfg_new_thresh_spike got=%b exp=0", b0.spike_vec[2]); end
        @(posedge clk); #1;
        checks++; if (q0.size() != 0) begin
            errors++; $display("FAIL cfg_missing_events got=%0d pending exp=0", q0.size()); end
    endtask

    task automatic test_mode1();
        logic [7:0] c;
        logic sp;
        do_reset();
        for (int f = 1; f <= 6; f++) begin
            for (int n = 0; n < 8; n++) begin
                c  = (n != 0) ? 8'd0 : (f <= 2) ? 8'd100 : (f == 6) ? 8'd122 : 8'd0;
                sp = (n == 0) && (f == 2 || f == 6);
                if (sp) q1.push_back(3'(n));
                beat(1, c);
                checks++; if (b1.spike_vec[n] !== sp) begin
                    errors++; $display("FAIL mode1_spike f=%0d n=%0d got=%b exp=%b", f, n, b1.spike_vec[n], sp); end
            end
        end
        @(posedge clk); #1;
        checks++; if (q1.size() != 0) begin
            errors++; $display("FAIL mode1_missing_events got=%0d pending exp=0", q1.size()); end
    endtask

    task automatic test_backpressure();
        do_reset();
        b0.evt_ready = 0;
        beat(0, 8'd0);
        beat(0, 8'd0);
        q0.push_back(3'd2);
        beat(0, 8'd200);
        checks++; if (b0.evt_valid !== 1'b1 || b0.evt_idx !== 3'd2 || b0.in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_spike got v=%b i=%0d rdy=%b exp v=1 i=2 rdy=0", b0.evt_valid, b0.evt_idx, b0.in_ready); end
        b0.in_valid = 1; b0.in_current = 8'd200;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++; if (b0.in_ready !== 1'b0 || b0.cur_idx !== 3'd3 || b0.evt_idx !== 3'd2 || b0.spike_vec !== 8'h04) begin
                errors++; $display("FAIL bp_stall k=%0d got rdy=%b idx=%0d ei=%0d sv=%h exp rdy=0 idx=3 ei=2 sv=04",
                                   k, b0.in_ready, b0.cur_idx, b0.evt_idx, b0.spike_vec); end
        end
        b0.evt_ready = 1; b0.in_current = 8'd100;
        @(posedge clk); #1;
        b0.in_valid = 0;
        checks++; if (b0.cur_idx !== 3'd4 || b0.evt_valid !== 1'b0 || b0.spike_vec[3] !== 1'b0) begin
            errors++; $display("FAIL bp_release got idx=%0d v=%b sp3=%b exp idx=4 v=0 sp3=0", b0.cur_idx, b0.evt_valid, b0.spike_vec[3]); end
        checks++; if (q0.size() != 0) begin
            errors++; $display("FAIL bp_missing_events got=%0d pending exp=0", q0.size()); end
    endtask

    task automatic test_n5();
        do_reset();
        cfg(5, 3'd6, 8'd0);
        for (int f = 1; f <= 2; f++) begin
            for (int n = 0; n < 5; n++) begin
                if (f == 2) q5.push_back(3'(n));
                beat(5, 8'd100);
                checks++; if (b5.cur_idx !== 3'((n + 1) % 5)) begin
                    errors++; $display("FAIL n5_cur_idx f=%0d got=%0d exp=%0d", f, b5.cur_idx, (n + 1) % 5); end
                checks++; if (b5.frame_done !== (n == 4)) begin
                    errors++; $display("FAIL n5_frame_done f=%0d n=%0d got=%b exp=%b", f, n, b5.frame_done, n == 4); end
                checks++; if (b5.spike_vec[n] !== (f == 2)) begin
                    errors++; $display("FAIL n5_spike f=%0d n=%0d got=%b exp=%b", f, n, b5.spike_vec[n], f == 2); end
            end
        end
        @(posedge clk); #1;
        checks++; if (b5.frame_done !== 1'b0 || q5.size() != 0) begin
            errors++; $display("FAIL n5_end got fd=%b pending=%0d exp fd=0 pending=0", b5.frame_done, q5.size()); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        cfg(0, 3'd1, 8'd40);
        b0.evt_ready = 0;
        beat(0, 8'd0);
        beat(0, 8'd0);
        beat(0, 8'd200);
        checks++; if (b0.cur_idx !== 3'd3 || b0.evt_valid !== 1'b1) begin
            errors++; $display("FAIL rmid_pre got idx=%0d v=%b exp idx=3 v=1", b0.cur_idx, b0.evt_valid); end
        rst = 1;
        #1;
        checks++; if (b0.cur_idx !== 3'd0 || b0.evt_valid !== 1'b0 || b0.spike_vec !== 8'h00) begin
            errors++; $display("FAIL rmid_async got idx=%0d v=%b sv=%h exp idx=0 v=0 sv=00", b0.cur_idx, b0.evt_valid, b0.spike_vec); end
        @(posedge clk); #1;
        rst = 0;
        b0.evt_ready = 1;
        beat(0, 8'd0);
        beat(0, 8'd100);
        checks++; if (b0.spike_vec[1] !== 1'b0 || b0.evt_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_thresh_restored got sp1=%b v=%b exp sp1=0 v=0", b0.spike_vec[1], b0.evt_valid); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_frames();
        test_saturation();
        test_cfg_same_cycle();
        test_mode1();
        test_backpressure();
        test_n5();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
